clap_monitor_369: RTL and testbench

//  Downstream consumer of the 369-game counter (sequence 0,3,6,9,13,6,9,13,...).

---
 rtl/clap_monitor_369.sv | 76 +++++++
 tb/tb_clap_monitor_369.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clap_monitor_369.sv
// clap_monitor_369: checks a 369-game count stream against its legal sequence,
// counts claps with saturation and drives a BCD split of each sampled value.
module clap_monitor_369 #(
   parameter int CW         = 8,
   parameter bit ALLOW_HOLD = 1'b0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [3:0]    count,
   output logic          clap,
   output logic [CW-1:0] clap_total,
   output logic          seq_err,
   output logic [3:0]    err_value,
   output logic [3:0]    bcd_tens,
   output logic [3:0]    bcd_ones,
   output logic [1:0]    state
);
   localparam logic [1:0] WAIT = 2'b00, RUN = 2'b01, ERR = 2'b10;
   logic [1:0]    state_q, state_d;
   logic [3:0]    prev_q;
   logic          clap_q, clap_d;
   logic [CW-1:0] total_q, total_d;
   logic          err_q, err_d;
   logic [3:0]    ev_q, ev_d;
   logic [3:0]    tens_q, ones_q;
   logic          hold, legal, earns, enter_err;
   always_comb begin
      hold  = ALLOW_HOLD && (count == prev_q);
      legal = (prev_q == 4'd0  && count == 4'd3)  ||
              (prev_q == 4'd3  && count == 4'd6)  ||
              (prev_q == 4'd6  && count == 4'd9)  ||
              (prev_q == 4'd9  && count == 4'd13) ||
              (prev_q == 4'd13 && count == 4'd6)  || hold;
      earns = count == 4'd3 || count == 4'd6 || count == 4'd9 || count == 4'd13;
   end
   always_comb begin
      state_d = state_q == WAIT ? (count == 4'd0 ? RUN : ERR) :
                state_q == RUN  ? (legal ? RUN : ERR) : ERR;
   end
   // A hold never claps; each clapping value carries exactly one 3/6/9 digit.
   always_comb begin
      enter_err = state_d == ERR && state_q != ERR;
      clap_d    = state_q == RUN && legal && earns && !hold;
      total_d   = clap_d && !(&total_q) ? total_q + 1'b1 : total_q;
      err_d     = err_q | enter_err;
      ev_d      = enter_err ? count : ev_q;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= WAIT;
         prev_q  <= '0;
         clap_q  <= 1'b0;
         total_q <= '0;
         err_q   <= 1'b0;
         ev_q    <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= count;
         clap_q  <= clap_d;
         total_q <= total_d;
         err_q   <= err_d;
         ev_q    <= ev_d;
         tens_q  <= {3'b000, count >= 4'd10};
         ones_q  <= count >= 4'd10 ? count - 4'd10 : count;
      end
   end
   assign state      = state_q;
   assign clap       = clap_q;
   assign clap_total = total_q;
   assign seq_err    = err_q;
   assign err_value  = ev_q;
   assign bcd_tens   = tens_q;
   assign bcd_ones   = ones_q;
endmodule

// File: tb/tb_clap_monitor_369.sv
// tb_clap_monitor_369: vector table with scoreboard for the default build,
// plus hand sequences for clap_total saturation (CW=3) and ALLOW_HOLD=1.
module tb_clap_monitor_369;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] count = 4'd0;
   always #5 clk = ~clk;

   logic       m_clap, s_clap, h_clap, m_err, s_err, h_err;
   logic [7:0] m_total, h_total;
   logic [2:0] s_total;
   logic [3:0] m_ev, s_ev, h_ev, m_tens, s_tens, h_tens, m_ones, s_ones, h_ones;
   logic [1:0] m_st, s_st, h_st;

   clap_monitor_369 u_main (.clk(clk), .reset_n(reset_n), .count(count), .clap(m_clap),
      .clap_total(m_total), .seq_err(m_err), .err_value(m_ev), .bcd_tens(m_tens),
      .bcd_ones(m_ones), .state(m_st));
   clap_monitor_369 #(.CW(3)) u_sat (.clk(clk), .reset_n(reset_n), .count(count), .clap(s_clap),
      .clap_total(s_total), .seq_err(s_err), .err_value(s_ev), .bcd_tens(s_tens),
      .bcd_ones(s_ones), .state(s_st));
   clap_monitor_369 #(.ALLOW_HOLD(1'b1)) u_hold (.clk(clk), .reset_n(reset_n), .count(count),
      .clap(h_clap), .clap_total(h_total), .seq_err(h_err), .err_value(h_ev), .bcd_tens(h_tens),
      .bcd_ones(h_ones), .state(h_st));

   typedef struct {
      logic       rst_n;
      logic [3:0] cnt;
      logic       clap;
      logic [7:0] total;
      logic       err;
      logic [3:0] ev;
      logic [3:0] tens;
      logic [3:0] ones;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic r, logic [3:0] c, logic cl, logic [7:0] t, logic e,
                               logic [3:0] ev, logic [3:0] tn, logic [3:0] on, logic [1:0] st);
      vec_t v;
      v.rst_n = r; v.cnt = c; v.clap = cl; v.total = t; v.err = e;
      v.ev = ev; v.tens = tn; v.ones = on; v.st = st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] c);
      @(negedge clk);
      reset_n = r;
      count   = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      int   seq[12] = '{3, 6, 9, 13, 6, 9, 13, 6, 9, 13, 6, 9};
      // T1: reset then the canonical sequence
      vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3,  1, 1, 0, 0, 0, 3, 1));
      vecs.push_back(mk(1, 6,  1, 2, 0, 0, 0, 6, 1));
      vecs.push_back(mk(1, 9,  1, 3, 0, 0, 0, 9, 1));
      vecs.push_back(mk(1, 13, 1, 4, 0, 0, 1, 3, 1));
      vecs.push_back(mk(1, 6,  1, 5, 0, 0, 0, 6, 1));
      vecs.push_back(mk(1, 9,  1, 6, 0, 0, 0, 9, 1));
      vecs.push_back(mk(1, 13, 1, 7, 0, 0, 1, 3, 1));
      // T3: bad first sample, ERR absorbs later legal values
      vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5,  0, 0, 1, 5, 0, 5, 2));
      vecs.push_back(mk(1, 0,  0, 0, 1, 5, 0, 0, 2));
      vecs.push_back(mk(1, 3,  0, 0, 1, 5, 0, 3, 2));
      // T4: illegal 9->6 freezes total and err_value
      vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3,  1, 1, 0, 0, 0, 3, 1));
      vecs.push_back(mk(1, 6,  1, 2, 0, 0, 0, 6, 1));
      vecs.push_back(mk(1, 9,  1, 3, 0, 0, 0, 9, 1));
      vecs.push_back(mk(1, 6,  0, 3, 1, 6, 0, 6, 2));
      vecs.push_back(mk(1, 9,  0, 3, 1, 6, 0, 9, 2));
      vecs.push_back(mk(1, 13, 0, 3, 1, 6, 1, 3, 2));
      // T5: mid-run reset
      vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3,  1, 1, 0, 0, 0, 3, 1));
      vecs.push_back(mk(1, 6,  1, 2, 0, 0, 0, 6, 1));
      vecs.push_back(mk(0, 9,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3,  1, 1, 0, 0, 0, 3, 1));
      // T6 with ALLOW_HOLD=0: repeated 3 is an error
      vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3,  1, 1, 0, 0, 0, 3, 1));
      vecs.push_back(mk(1, 3,  0, 1, 1, 3, 0, 3, 2));
      vecs.push_back(mk(1, 6,  0, 1, 1, 3, 0, 6, 2));
      // out-of-range value 12 after 9
      vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 3,  1, 1, 0, 0, 0, 3, 1));
      vecs.push_back(mk(1, 6,  1, 2, 0, 0, 0, 6, 1));
      vecs.push_back(mk(1, 9,  1, 3, 0, 0, 0, 9, 1));
      vecs.push_back(mk(1, 12, 0, 3, 1, 12, 1, 2, 2));

      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i]);
         step(vecs[i].rst_n, vecs[i].cnt);
         e = exp_q.pop_front();
         chk($sformatf("vec%0d clap/total/err/ev/tens/ones/state", i),
             {8'd0, m_clap, m_total, m_err, m_ev, m_tens, m_ones, m_st},
             {8'd0, e.clap, e.total, e.err, e.ev, e.tens, e.ones, e.st});
      end

      // T2: CW=3 saturates at 7, clap keeps pulsing
      step(0, 0);
      step(1, 0);
      for (int i = 0; i < 12; i++) begin
         step(1, 4'(seq[i]));
         chk($sformatf("sat%0d clap", i), {31'd0, s_clap}, 32'd1);
         chk($sformatf("sat%0d total", i), {29'd0, s_total}, (i + 1 > 7) ? 32'd7 : 32'(i + 1));
      end
      chk("sat seq_err", {31'd0, s_err}, 32'd0);

      // T6 with ALLOW_HOLD=1: hold is legal and silent
      step(0, 0);
      step(1, 0);
      step(1, 3);
      chk("hold first3 clap/total/st", {h_clap, h_total, h_st}, {1'b1, 8'd1, 2'b01});
      step(1, 3);
      chk("hold second3 clap/total/st", {h_clap, h_total, h_st}, {1'b0, 8'd1, 2'b01});
      step(1, 6);
      chk("hold six clap/total/st", {h_clap, h_total, h_st}, {1'b1, 8'd2, 2'b01});
      chk("hold seq_err", {31'd0, h_err}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
